// File: rtl/crash_detect_pkg.sv
// Shared defaults and player FSM encoding for the crash_detect collision arbiter.
// Optional feature macro used by the top level: CRASH_INVINCIBLE_EN.
package crash_detect_pkg;

    localparam int ENEMY_TYPES_DEF       = 3;
    localparam int INVINCIBLE_FRAMES_DEF = 120;
    localparam int HIT_CNT_WIDTH_DEF     = 16;

    typedef enum logic {
        ME_ARMED = 1'b0,
        ME_GUARD = 1'b1
    } me_state_e;

endpackage

// File: rtl/crash_detect_crash_gate.sv
// One enemy type's collision gate: raw overlap AND plus once-per-frame suppression flags.
module crash_gate (
    input  logic clk_vga,
    input  logic rst_n,
    input  logic en_i,
    input  logic fe_i,
    input  logic enemy_alpha_i,
    input  logic bullet_alpha_i,
    input  logic me_alpha_i,
    output logic raw_m_o,
    output logic crash_b_o,
    output logic crash_m_o
);

    logic raw_b;
    logic bdone_q, bdone_d;
    logic mdone_q, mdone_d;

    always_comb begin
        raw_b     = en_i & enemy_alpha_i & bullet_alpha_i;
        raw_m_o   = en_i & enemy_alpha_i & me_alpha_i;
        crash_m_o = raw_m_o & ~mdone_q;
        // Player contact wins the pixel, so the bullet flag stays clear for a later hit.
        crash_b_o = raw_b & ~bdone_q & ~crash_m_o;

        bdone_d = bdone_q;
        mdone_d = mdone_q;
        if (!en_i) begin
            bdone_d = 1'b0;
            mdone_d = 1'b0;
        end else begin
            if (crash_b_o)  bdone_d = 1'b1;
            else if (fe_i)  bdone_d = 1'b0;
            if (crash_m_o)  mdone_d = 1'b1;
            else if (fe_i)  mdone_d = 1'b0;
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            bdone_q <= 1'b0;
            mdone_q <= 1'b0;
        end else begin
            bdone_q <= bdone_d;
            mdone_q <= mdone_d;
        end
    end

endmodule

// File: rtl/crash_detect.sv
// Per-pixel collision arbiter: zero-latency crash strobes, player guard FSM, bullet hit counter.
// Define CRASH_INVINCIBLE_EN for a multi-frame guard window of INVINCIBLE_FRAMES frames.
module crash_detect
    import crash_detect_pkg::*;
#(
    parameter int ENEMY_TYPES       = ENEMY_TYPES_DEF,
    parameter int INVINCIBLE_FRAMES = INVINCIBLE_FRAMES_DEF,
    parameter int HIT_CNT_WIDTH     = HIT_CNT_WIDTH_DEF
) (
    input  logic                     clk_vga,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     v_sync_i,
    input  logic [ENEMY_TYPES-1:0]   enemy_alpha_i,
    input  logic                     bullet_alpha_i,
    input  logic                     me_alpha_i,
    output logic [ENEMY_TYPES-1:0]   crash_enemy_bullet_o,
    output logic [ENEMY_TYPES-1:0]   crash_me_enemy_o,
    output logic                     bullet_hit_o,
    output logic                     me_hit_o,
    output logic                     me_invincible_o,
    output logic [HIT_CNT_WIDTH-1:0] hit_cnt_o
);

    if (INVINCIBLE_FRAMES < 1 || INVINCIBLE_FRAMES > 255) begin : g_bad_frames
        $error("INVINCIBLE_FRAMES must be within 1..255");
    end

    function automatic logic [HIT_CNT_WIDTH-1:0] sat_inc(input logic [HIT_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                     vs_q, vs_d;
    logic                     fe;
    logic [ENEMY_TYPES-1:0]   raw_m;
    logic                     guard_done;
    me_state_e                state_q, state_d;
    logic [HIT_CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;

    for (genvar t = 0; t < ENEMY_TYPES; t++) begin : g_gate
        crash_gate u_gate (
            .clk_vga        (clk_vga),
            .rst_n          (rst_n),
            .en_i           (en_i),
            .fe_i           (fe),
            .enemy_alpha_i  (enemy_alpha_i[t]),
            .bullet_alpha_i (bullet_alpha_i),
            .me_alpha_i     (me_alpha_i),
            .raw_m_o        (raw_m[t]),
            .crash_b_o      (crash_enemy_bullet_o[t]),
            .crash_m_o      (crash_me_enemy_o[t])
        );
    end

`ifdef CRASH_INVINCIBLE_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        guard_done  = (frame_cnt_q == 8'(INVINCIBLE_FRAMES - 1));
        frame_cnt_d = frame_cnt_q;
        if (!en_i)
            frame_cnt_d = 8'd0;
        else if (state_q == ME_ARMED && |raw_m)
            frame_cnt_d = 8'd0;
        else if (state_q == ME_GUARD && fe)
            frame_cnt_d = frame_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= 8'd0;
        else        frame_cnt_q <= frame_cnt_d;
    end
`else
    assign guard_done = 1'b1;
`endif

    always_comb begin
        vs_d         = v_sync_i;
        fe           = v_sync_i & ~vs_q;
        bullet_hit_o = |crash_enemy_bullet_o;
        me_hit_o     = (state_q == ME_ARMED) & (|raw_m);

        state_d = state_q;
        if (!en_i) begin
            state_d = ME_ARMED;
        end else begin
            case (state_q)
                ME_ARMED: if (|raw_m)           state_d = ME_GUARD;
                ME_GUARD: if (fe && guard_done) state_d = ME_ARMED;
                default:                        state_d = ME_ARMED;
            endcase
        end

        hit_cnt_d = bullet_hit_o ? sat_inc(hit_cnt_q) : hit_cnt_q;
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            state_q   <= ME_ARMED;
            hit_cnt_q <= '0;
        end else begin
            vs_q      <= vs_d;
            state_q   <= state_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign me_invincible_o = (state_q == ME_GUARD);
    assign hit_cnt_o       = hit_cnt_q;

endmodule

// File: tb/tb_crash_detect.sv
// Randomized bench for crash_detect against a frame-numbered reference model.
module tb_crash_detect;

    localparam int NT = 3;
    localparam int NF = 3;
    localparam int HW = 4;
    localparam int HMAX = (1 << HW) - 1;

    logic          clk_vga = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic          v_sync_i = 1'b0;
    logic [NT-1:0] enemy_alpha_i = '0;
    logic          bullet_alpha_i = 1'b0;
    logic          me_alpha_i = 1'b0;
    logic [NT-1:0] crash_enemy_bullet_o;
    logic [NT-1:0] crash_me_enemy_o;
    logic          bullet_hit_o;
    logic          me_hit_o;
    logic          me_invincible_o;
    logic [HW-1:0] hit_cnt_o;

    crash_detect #(
        .ENEMY_TYPES       (NT),
        .INVINCIBLE_FRAMES (NF),
        .HIT_CNT_WIDTH     (HW)
    ) dut (
        .clk_vga              (clk_vga),
        .rst_n                (rst_n),
        .en_i                 (en_i),
        .v_sync_i             (v_sync_i),
        .enemy_alpha_i        (enemy_alpha_i),
        .bullet_alpha_i       (bullet_alpha_i),
        .me_alpha_i           (me_alpha_i),
        .crash_enemy_bullet_o (crash_enemy_bullet_o),
        .crash_me_enemy_o     (crash_me_enemy_o),
        .bullet_hit_o         (bullet_hit_o),
        .me_hit_o             (me_hit_o),
        .me_invincible_o      (me_invincible_o),
        .hit_cnt_o            (hit_cnt_o)
    );

    always #5 clk_vga = ~clk_vga;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a hit on type t is blocked while it was already recorded in
    // the current frame number; guard counts remaining frame edges down to zero.
    int frame_no;
    int last_b[NT];
    int last_m[NT];
    bit guard;
    int fes_left;
    int hits;
    bit prev_vs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_no = 0;
        for (int t = 0; t < NT; t++) begin
            last_b[t] = -1;
            last_m[t] = -1;
        end
        guard    = 0;
        fes_left = 0;
        hits     = 0;
        prev_vs  = 0;
    endtask

    task automatic step(input bit rstn, input bit en, input bit vs,
                        input logic [NT-1:0] ea, input bit ba, input bit ma);
        logic [NT-1:0] exp_b, exp_m;
        bit fe, contact, exp_mehit;
        @(negedge clk_vga);
        rst_n = rstn; en_i = en; v_sync_i = vs;
        enemy_alpha_i = ea; bullet_alpha_i = ba; me_alpha_i = ma;
        #1;
        if (!rstn) model_reset();
        fe = vs && !prev_vs;
        contact = 0;
        for (int t = 0; t < NT; t++) begin
            bit rb, rm;
            rb = en && ea[t] && ba;
            rm = en && ea[t] && ma;
            if (rm) contact = 1;
            exp_m[t] = rm && (last_m[t] != frame_no);
            exp_b[t] = rb && (last_b[t] != frame_no) && !exp_m[t];
        end
        exp_mehit = contact && !guard;

        chk("crash_b", 32'(crash_enemy_bullet_o), 32'(exp_b));
        chk("crash_m", 32'(crash_me_enemy_o), 32'(exp_m));
        chk("bullet_hit", 32'(bullet_hit_o), 32'(|exp_b));
        chk("me_hit", 32'(me_hit_o), 32'(exp_mehit));
        chk("invincible", 32'(me_invincible_o), 32'(guard));
        chk("hit_cnt", 32'(hit_cnt_o), 32'(hits));

        if (rstn) begin
            if (!en) begin
                for (int t = 0; t < NT; t++) begin
                    last_b[t] = -1;
                    last_m[t] = -1;
                end
                guard = 0;
            end else begin
                if (fe) frame_no++;
                for (int t = 0; t < NT; t++) begin
                    if (exp_b[t]) last_b[t] = frame_no;
                    if (exp_m[t]) last_m[t] = frame_no;
                end
                if (!guard) begin
                    if (contact) begin
                        guard = 1;
`ifdef CRASH_INVINCIBLE_EN
                        fes_left = NF;
`else
                        fes_left = 1;
`endif
                    end
                end else if (fe) begin
                    fes_left--;
                    if (fes_left == 0) guard = 0;
                end
            end
            if (|exp_b) hits = (hits + 1 > HMAX) ? HMAX : hits + 1;
            prev_vs = vs;
        end
        @(posedge clk_vga);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, '0, 0, 0);
    endtask

    task automatic frame_edge();
        step(1, 1, 1, '0, 0, 0);
        step(1, 1, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 1, 0, '0, 0, 0);
        step(0, 1, 0, '0, 0, 0);
    endtask

    initial begin
        model_reset();

        // Repeated bullet overlap: one pulse per frame
        do_reset();
        chk("rst_inv", 32'(me_invincible_o), 32'd0);
        chk("rst_cnt", 32'(hit_cnt_o), 32'd0);
        idle(3);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 3'b001, 1, 0);
        chk("t1_cnt1", 32'(hit_cnt_o), 32'd1);
        frame_edge();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 3'b001, 1, 0);
        chk("t1_cnt2", 32'(hit_cnt_o), 32'd2);

        // Player contact has priority over the bullet
        do_reset();
        idle(2);
        step(1, 1, 0, 3'b101, 1, 1);
        chk("t2_inv", 32'(me_invincible_o), 32'd1);
        chk("t2_cnt", 32'(hit_cnt_o), 32'd0);

        // Guard window across frames
        for (int f = 0; f < NF + 1; f++) begin
            frame_edge();
            step(1, 1, 0, 3'b010, 0, 1);
            idle(1);
        end

        // Bullet overlap on the frame edge keeps the flag set
        do_reset();
        idle(2);
        step(1, 1, 1, 3'b010, 1, 0);
        step(1, 1, 1, 3'b010, 1, 0);
        step(1, 1, 0, 3'b010, 1, 0);
        chk("t4_cnt", 32'(hit_cnt_o), 32'd1);

        // Hit counter saturation
        do_reset();
        for (int f = 0; f < 16; f++) begin
            step(1, 1, 0, 3'b001, 1, 0);
            frame_edge();
        end
        chk("t5_sat", 32'(hit_cnt_o), 32'(HMAX));
        step(1, 1, 0, 3'b100, 1, 0);
        chk("t5_hold", 32'(hit_cnt_o), 32'(HMAX));

        // Mid-frame reset with guard active and flags set
        do_reset();
        idle(2);
        step(1, 1, 0, 3'b011, 1, 1);
        step(1, 1, 0, 3'b100, 1, 0);
        step(0, 1, 0, '0, 0, 0);
        chk("t6_inv", 32'(me_invincible_o), 32'd0);
        chk("t6_cnt", 32'(hit_cnt_o), 32'd0);
        step(1, 1, 0, 3'b100, 1, 0);
        step(1, 1, 0, 3'b001, 0, 1);
        for (int i = 0; i < 10; i++)
            step(1, 0, $urandom_range(0, 1), 3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
        chk("t6_en0_cnt", 32'(hit_cnt_o), 32'd1);

        // Randomized frames
        do_reset();
        for (int f = 0; f < 150; f++) begin
            int len;
            len = $urandom_range(5, 25);
            for (int i = 0; i < len; i++)
                step(($urandom % 300) != 0, ($urandom % 25) != 0, 0, 3'($urandom),
                     ($urandom % 3) == 0, ($urandom % 4) == 0);
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++)
                step(1, ($urandom % 25) != 0, 1, 3'($urandom),
                     ($urandom % 3) == 0, ($urandom % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
